// File: rtl/dfp_arbiter.sv
// Two-port arbiter sharing one cache-line memory port between an I-cache and a D-cache.
// One transaction at a time; round-robin or fixed D priority chosen by FAIR.
module dfp_arbiter #(
    parameter int FAIR = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  i_addr,
    input  logic         i_read,
    input  logic         i_write,
    input  logic [255:0] i_wdata,
    output logic [255:0] i_rdata,
    output logic         i_resp,
    input  logic [31:0]  d_addr,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [255:0] d_wdata,
    output logic [255:0] d_rdata,
    output logic         d_resp,
    output logic [31:0]  dfp_addr,
    output logic         dfp_read,
    output logic         dfp_write,
    output logic [255:0] dfp_wdata,
    input  logic [255:0] dfp_rdata,
    input  logic         dfp_resp,
    output logic         err,
    output logic [1:0]   dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;  // 0 = I served last, 1 = D served last

    logic         i_pend;
    logic         d_pend;
    logic         pick_d;
    logic [31:0]  sel_addr;
    logic         sel_read;
    logic         sel_write;
    logic [255:0] sel_wdata;

    assign i_pend = i_read | i_write;
    assign d_pend = d_read | d_write;

    // With both pending: FAIR alternates away from the last served side, else D wins.
    always_comb begin
        pick_d = 1'b0;
        if (d_pend && !i_pend) begin
            pick_d = 1'b1;
        end else if (d_pend && i_pend) begin
            pick_d = (FAIR != 0) ? !last_grant : 1'b1;
        end
    end

    always_comb begin
        sel_addr  = i_addr;
        sel_read  = i_read;
        sel_write = i_write;
        sel_wdata = i_wdata;
        if (pick_d) begin
            sel_addr  = d_addr;
            sel_read  = d_read;
            sel_write = d_write;
            sel_wdata = d_wdata;
        end
    end

    // The dfp_* registers double as the latched request and are only nonzero while busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            dfp_addr   <= '0;
            dfp_read   <= 1'b0;
            dfp_write  <= 1'b0;
            dfp_wdata  <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dfp_resp) begin
                        err <= 1'b1;
                    end
                    if (i_pend || d_pend) begin
                        state     <= pick_d ? BUSY_D : BUSY_I;
                        dfp_addr  <= {sel_addr[31:5], 5'b0};
                        dfp_write <= sel_write;
                        dfp_read  <= sel_read & ~sel_write;
                        dfp_wdata <= sel_wdata;
                        if (sel_read && sel_write) begin
                            err <= 1'b1;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (dfp_resp) begin
                        last_grant <= (state == BUSY_D);
                        state      <= DONE;
                        dfp_addr   <= '0;
                        dfp_read   <= 1'b0;
                        dfp_write  <= 1'b0;
                        dfp_wdata  <= '0;
                    end
                end
                DONE: begin
                    if (dfp_resp) begin
                        err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign i_resp    = (state == BUSY_I) && dfp_resp;
    assign d_resp    = (state == BUSY_D) && dfp_resp;
    assign i_rdata   = i_resp ? dfp_rdata : '0;
    assign d_rdata   = d_resp ? dfp_rdata : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_dfp_arbiter.sv
// Directed bench for dfp_arbiter: a vector table of single-requester transactions
// plus hand-written arbitration, stray-response and reset sequences.
module tb_dfp_arbiter;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY_I = 2'd1;
    localparam logic [1:0] S_BUSY_D = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic         clk;
    logic         rst;
    logic [31:0]  i_addr;
    logic         i_read;
    logic         i_write;
    logic [255:0] i_wdata;
    logic [31:0]  d_addr;
    logic         d_read;
    logic         d_write;
    logic [255:0] d_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;

    logic [255:0] i_rdata, d_rdata, dfp_wdata;
    logic         i_resp, d_resp, dfp_read, dfp_write, err;
    logic [31:0]  dfp_addr;
    logic [1:0]   dbg_state;

    logic [255:0] fx_i_rdata, fx_d_rdata, fx_dfp_wdata;
    logic         fx_i_resp, fx_d_resp, fx_dfp_read, fx_dfp_write, fx_err;
    logic [31:0]  fx_dfp_addr;
    logic [1:0]   fx_state;

    int total = 0;
    int bad   = 0;

    dfp_arbiter #(.FAIR(1)) u_fair (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write), .dfp_wdata(dfp_wdata),
        .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .err(err), .dbg_state(dbg_state)
    );

    dfp_arbiter #(.FAIR(0)) u_fix (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
        .i_rdata(fx_i_rdata), .i_resp(fx_i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(fx_d_rdata), .d_resp(fx_d_resp),
        .dfp_addr(fx_dfp_addr), .dfp_read(fx_dfp_read), .dfp_write(fx_dfp_write), .dfp_wdata(fx_dfp_wdata),
        .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
        .err(fx_err), .dbg_state(fx_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic         side;      // 0 = I, 1 = D
        logic [31:0]  addr;
        logic         rd;
        logic         wr;
        logic [255:0] wdata;
        int           lat;
        logic [255:0] rdata;
        logic [31:0]  exp_addr;
        logic         exp_rd;
        logic         exp_wr;
        logic         exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_reqs();
        i_addr = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = '0;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
        dfp_resp = 1'b0; dfp_rdata = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Single-requester transaction: request at IDLE, hold through BUSY, drop at DONE.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.side) begin
            d_addr = v.addr; d_read = v.rd; d_write = v.wr; d_wdata = v.wdata;
        end else begin
            i_addr = v.addr; i_read = v.rd; i_write = v.wr; i_wdata = v.wdata;
        end
        #1;
        chk({tag, "_idle_state"}, 256'(dbg_state), 256'(S_IDLE));
        step();
        for (int k = 1; k <= v.lat; k++) begin
            dfp_resp  = (k == v.lat);
            dfp_rdata = (k == v.lat) ? v.rdata : {8{$urandom}};
            #1;
            chk({tag, "_busy_state"}, 256'(dbg_state), v.side ? 256'(S_BUSY_D) : 256'(S_BUSY_I));
            chk({tag, "_dfp_addr"}, 256'(dfp_addr), 256'(v.exp_addr));
            chk({tag, "_dfp_read"}, 256'(dfp_read), 256'(v.exp_rd));
            chk({tag, "_dfp_write"}, 256'(dfp_write), 256'(v.exp_wr));
            chk({tag, "_dfp_wdata"}, dfp_wdata, v.wdata);
            chk({tag, "_fix_dfp_addr"}, 256'(fx_dfp_addr), 256'(v.exp_addr));
            if (v.side) begin
                chk({tag, "_d_resp"}, 256'(d_resp), 256'(k == v.lat));
                chk({tag, "_d_rdata"}, d_rdata, (k == v.lat) ? v.rdata : 256'd0);
                chk({tag, "_i_quiet"}, {255'd0, i_resp} | i_rdata, 256'd0);
            end else begin
                chk({tag, "_i_resp"}, 256'(i_resp), 256'(k == v.lat));
                chk({tag, "_i_rdata"}, i_rdata, (k == v.lat) ? v.rdata : 256'd0);
                chk({tag, "_d_quiet"}, {255'd0, d_resp} | d_rdata, 256'd0);
            end
            step();
        end
        dfp_resp = 1'b0;
        dfp_rdata = '0;
        clear_reqs();
        #1;
        chk({tag, "_done_state"}, 256'(dbg_state), 256'(S_DONE));
        chk({tag, "_done_dfp_rw"}, 256'({dfp_read, dfp_write}), 256'd0);
        chk({tag, "_done_dfp_addr"}, 256'(dfp_addr), 256'd0);
        chk({tag, "_err"}, 256'(err), 256'(v.exp_err));
        step();
        chk({tag, "_back_idle"}, 256'(dbg_state), 256'(S_IDLE));
    endtask

    logic [255:0] pat_p;
    logic [31:0]  exp_a;
    logic         exp_d;

    initial begin
        pat_p = {8{32'hDEAD_BEEF}} ^ {64{4'h5}};
        vecs[0] = '{1'b0, 32'h0000_1234, 1'b1, 1'b0, 256'd0, 3, {32{8'hA5}},
                    32'h0000_1220, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h8000_0041, 1'b1, 1'b0, 256'd0, 1, {8{32'h1234_5678}},
                    32'h8000_0040, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, {16{16'hC3C3}}, 2, 256'd0,
                    32'hFFFF_FFE0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h8000_0040, 1'b1, 1'b1, pat_p, 2, 256'd0,
                    32'h8000_0040, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 32'h0000_003F, 1'b1, 1'b0, 256'd0, 1, {4{64'h0F0F_0000_FFFF_0001}},
                    32'h0000_0020, 1'b1, 1'b0, 1'b1};

        // Reset state, sampled while reset is held.
        clear_reqs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_state", 256'(dbg_state), 256'(S_IDLE));
        chk("rst_dfp", 256'({dfp_addr, dfp_read, dfp_write}), 256'd0);
        chk("rst_wdata", dfp_wdata, 256'd0);
        chk("rst_resp", 256'({i_resp, d_resp, err}), 256'd0);
        rst = 1'b1;
        step();

        foreach (vecs[n]) run_vec(vecs[n], n);

        // Both sides contending: fair instance alternates D,I,D,I; fixed one always D.
        do_reset();
        i_addr = 32'h0000_0100; i_read = 1'b1;
        d_addr = 32'h0000_0200; d_read = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_d = (g % 2 == 0);
            exp_a = exp_d ? 32'h0000_0200 : 32'h0000_0100;
            #1;
            chk($sformatf("arb%0d_idle", g), 256'(dbg_state), 256'(S_IDLE));
            step();
            dfp_resp = 1'b1;
            dfp_rdata = {8{32'(g + 1)}};
            #1;
            chk($sformatf("arb%0d_state", g), 256'(dbg_state), exp_d ? 256'(S_BUSY_D) : 256'(S_BUSY_I));
            chk($sformatf("arb%0d_addr", g), 256'(dfp_addr), 256'(exp_a));
            chk($sformatf("arb%0d_resp", g), 256'({i_resp, d_resp}), exp_d ? 256'd1 : 256'd2);
            chk($sformatf("arb%0d_fix_state", g), 256'(fx_state), 256'(S_BUSY_D));
            chk($sformatf("arb%0d_fix_resp", g), 256'({fx_i_resp, fx_d_resp}), 256'd1);
            step();
            dfp_resp = 1'b0;
            dfp_rdata = '0;
            if (exp_d) d_read = 1'b0; else i_read = 1'b0;
            #1;
            chk($sformatf("arb%0d_done", g), 256'(dbg_state), 256'(S_DONE));
            step();
            i_read = 1'b1;
            d_read = 1'b1;
        end
        clear_reqs();
        step();
        step();

        // Stray memory response while idle.
        do_reset();
        #1;
        chk("stray_err_before", 256'(err), 256'd0);
        dfp_resp = 1'b1;
        dfp_rdata = {32{8'h77}};
        #1;
        chk("stray_resp", 256'({i_resp, d_resp}), 256'd0);
        chk("stray_rdata", i_rdata | d_rdata, 256'd0);
        step();
        dfp_resp = 1'b0;
        #1;
        chk("stray_err", 256'(err), 256'd1);
        chk("stray_state", 256'(dbg_state), 256'(S_IDLE));
        step();
        chk("stray_err_sticky", 256'(err), 256'd1);

        // Reset in the middle of an I read, then a late memory response.
        do_reset();
        i_addr = 32'h0000_4444; i_read = 1'b1;
        step();
        #1;
        chk("mid_busy_i", 256'(dbg_state), 256'(S_BUSY_I));
        rst = 1'b0;
        #1;
        chk("mid_rst_state", 256'(dbg_state), 256'(S_IDLE));
        chk("mid_rst_dfp", 256'({dfp_addr, dfp_read, dfp_write}), 256'd0);
        chk("mid_rst_out", 256'({i_resp, d_resp, err}), 256'd0);
        clear_reqs();
        step();
        rst = 1'b1;
        step();
        dfp_resp = 1'b1;
        dfp_rdata = {32{8'h3C}};
        #1;
        chk("late_no_resp", 256'({i_resp, d_resp}), 256'd0);
        chk("late_no_rdata", i_rdata, 256'd0);
        step();
        dfp_resp = 1'b0;
        #1;
        chk("late_err", 256'(err), 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dfp_arbiter.md
DFP_ARBITER -- requirements
Module: dfp_arbiter

Interface
REQ-001 Parameter FAIR, default 1, 1 = round-robin between requesters, 0 = fixed priority to D-side.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 i_addr / i_read / i_write / i_wdata  in  32/1/1/256  I-cache line request.
REQ-005 i_rdata / i_resp  out  256/1  I-cache line return and completion pulse.
REQ-006 d_addr / d_read / d_write / d_wdata  in  32/1/1/256  D-cache line request.
REQ-007 d_rdata / d_resp  out  256/1  D-cache line return and completion pulse.
REQ-008 dfp_addr / dfp_read / dfp_write / dfp_wdata  out  32/1/1/256  shared memory port request.
REQ-009 dfp_rdata / dfp_resp  in  256/1  shared memory port return and completion.
REQ-010 err  out  1  sticky protocol-violation flag.

Function
REQ-011 States: IDLE, BUSY_I, BUSY_D, DONE; state register plus last_grant bit (I or D).
REQ-012 A requester is pending when its read or write is 1; requesters hold addr/read/write/wdata stable until their resp.
REQ-013 IDLE, one pending: grant it; next state BUSY_I or BUSY_D.
REQ-014 IDLE, both pending, FAIR=1: grant the side not equal to last_grant; FAIR=0: grant D.
REQ-015 On the grant edge, latch granted addr (bits [4:0] forced to 0), read, write, wdata into internal registers.
REQ-016 Read and write both 1 on the granted side: latch write=1, read=0, set err.
REQ-017 BUSY_x: dfp_addr/read/write/wdata driven from latched registers; held constant until dfp_resp.
REQ-018 BUSY_x with dfp_resp=1: x_resp=1 combinationally that cycle, x_rdata=dfp_rdata; last_grant<=x; next state DONE.
REQ-019 x_rdata is 0 whenever x_resp is 0; the non-granted side never sees resp or rdata.
REQ-020 DONE: dfp_read=dfp_write=0, no resp, no grant; next state IDLE unconditionally (one-cycle turnaround so the served requester drops its request).
REQ-021 Outside BUSY states dfp_read, dfp_write, dfp_addr, dfp_wdata are 0.
REQ-022 Latency: request seen in IDLE at cycle N -> dfp_read/write asserted cycle N+1; minimum request-to-resp 2 cycles with a 1-cycle memory.
REQ-023 dfp_resp=1 in IDLE or DONE: ignored (no resp forwarded), err set.
REQ-024 Requests arriving during BUSY/DONE wait; a waiting side is granted at the next IDLE per REQ-014, so with FAIR=1 no side waits more than one transaction.
REQ-025 Exactly one memory transaction outstanding at any time.
REQ-026 err is cleared only by reset.

Reset
REQ-027 rst=0 asynchronously forces state IDLE, last_grant=I, latched registers 0, err 0, all outputs 0.
REQ-028 Reset during BUSY abandons the in-flight transaction; no resp is issued for it after reset deasserts.
REQ-029 First arbitration after reset with both pending and FAIR=1 grants D.

Verification
REQ-030 I-only read addr 0x0000_1234, memory resp after 3 cycles with rdata 0xA5..A5 -> dfp_addr 0x0000_1220, dfp_read=1 for 3 cycles, i_resp single pulse with i_rdata 0xA5..A5, then DONE, then IDLE.
REQ-031 Both sides read from IDLE after reset, FAIR=1, sides held until served -> order D, I, D, I; each grant separated by one DONE cycle.
REQ-032 FAIR=0, both held continuously -> D granted every transaction; I never granted while D pending.
REQ-033 D write addr 0x8000_0040, wdata pattern P, plus read=1 -> dfp_write=1, dfp_read=0, dfp_wdata=P, err=1 and stays 1.
REQ-034 rst=0 mid BUSY_I, then memory resp 1 cycle after release -> no i_resp, err=1 (stray resp), outputs 0 during reset.
REQ-035 dfp_resp pulsed while IDLE with no requests -> no resp on either side, err=1.
